// File: rtl/data_sync_tx_pkg.sv
// Shared definitions for the toggle-handshake bus synchronizer blocks.
// Also imported by the reset synchronizer and data_sync_rx.
package data_sync_tx_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } sync_state_e;

    localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// Single-bit level synchronizer: a NUM_STAGES-deep flop chain with synchronous reset to 0.
// Also instantiated by data_sync_rx.
module bit_sync
    import data_sync_tx_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[NUM_STAGES-2:0], d_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-domain end of the toggle-handshake bus synchronizer: captures a word,
// flips REQ_TOGGLE, and waits for the synchronized ACK_TOGGLE to match it.
module data_sync_tx
    import data_sync_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 DATA_VALID,
    output logic                 DATA_READY,
    output logic [BUS_WIDTH-1:0] DATA_BUS,
    output logic                 REQ_TOGGLE,
    input  logic                 ACK_TOGGLE,
    output logic                 DONE,
    output logic                 OVERRUN,
    input  logic                 OVR_CLR
);

    sync_state_e          state_q, state_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 ack_s;

    // ACK_TOGGLE is sampled only by this chain.
    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (ACK_TOGGLE),
        .q_o  (ack_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (DATA_VALID && DATA_READY) begin
                    data_d  = DATA_IN;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word offered while busy is dropped; set takes priority over clear.
        if (OVR_CLR) begin
            ovr_d = 1'b0;
        end
        if (DATA_VALID && (state_q == WAIT_ACK)) begin
            ovr_d = 1'b1;
        end
    end

    assign DATA_READY = (state_q == IDLE) && !RST;
    assign DATA_BUS   = data_q;
    assign REQ_TOGGLE = req_q;
    assign DONE       = done_q;
    assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx; the destination side is modelled by driving ACK_TOGGLE by hand.
module tb_data_sync_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA_IN = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       DATA_READY;
    logic [7:0] DATA_BUS;
    logic       REQ_TOGGLE;
    logic       ACK_TOGGLE = 1'b0;
    logic       DONE;
    logic       OVERRUN;
    logic       OVR_CLR = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;

    data_sync_tx #(
        .BUS_WIDTH (8),
        .NUM_STAGES(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DATA_IN   (DATA_IN),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .DATA_BUS  (DATA_BUS),
        .REQ_TOGGLE(REQ_TOGGLE),
        .ACK_TOGGLE(ACK_TOGGLE),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN),
        .OVR_CLR   (OVR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch a word from an IDLE/DONE cycle and let the modelled destination
    // return the acknowledge in cycle k+3; ends in the DONE cycle k+6.
    task automatic xfer(input logic [7:0] d, input logic exp_req);
        DATA_IN    = d;
        DATA_VALID = 1'b1;
        step();                                   // edge k
        DATA_VALID = 1'b0;
        chk("xfer_bus", DATA_BUS, d);
        chk("xfer_req", REQ_TOGGLE, exp_req);
        chk("xfer_busy", DATA_READY, 1'b0);
        chk("xfer_done_k", DONE, 1'b0);
        step();                                   // k+1
        step();                                   // k+2
        step();                                   // k+3
        ACK_TOGGLE = exp_req;
        step();                                   // k+4
        chk("xfer_done_k4", DONE, 1'b0);
        step();                                   // k+5
        chk("xfer_done_k5", DONE, 1'b0);
        chk("xfer_ready_k5", DATA_READY, 1'b0);
        step();                                   // k+6
        chk("xfer_done_k6", DONE, 1'b1);
        chk("xfer_ready_k6", DATA_READY, 1'b1);
        chk("xfer_bus_hold", DATA_BUS, d);
        if (DONE === 1'b1) n_done++;
    endtask

    initial begin
        // Reset held for 3 cycles with activity on the inputs.
        DATA_IN = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            ACK_TOGGLE = ~ACK_TOGGLE;
            DATA_VALID = ~DATA_VALID;
            step();
            chk("rst_bus", DATA_BUS, 8'h00);
            chk("rst_req", REQ_TOGGLE, 1'b0);
            chk("rst_done", DONE, 1'b0);
            chk("rst_ovr", OVERRUN, 1'b0);
            chk("rst_ready", DATA_READY, 1'b0);
        end
        ACK_TOGGLE = 1'b0;
        DATA_VALID = 1'b0;
        RST        = 1'b0;
        #1;
        chk("ready_after_rst", DATA_READY, 1'b1);
        step();
        step();

        // Single transfer.
        xfer(8'hA5, 1'b1);
        step();
        chk("single_done_once", DONE, 1'b0);
        chk("single_ovr", OVERRUN, 1'b0);
        step();

        // Reset one cycle after launching 8'hFF; destination reset alongside.
        DATA_IN    = 8'hFF;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        chk("mid_bus_launch", DATA_BUS, 8'hFF);
        chk("mid_req_launch", REQ_TOGGLE, 1'b0);
        RST        = 1'b1;
        ACK_TOGGLE = 1'b0;
        step();
        chk("mid_rst_bus", DATA_BUS, 8'h00);
        chk("mid_rst_req", REQ_TOGGLE, 1'b0);
        chk("mid_rst_done", DONE, 1'b0);
        RST = 1'b0;
        #1;
        chk("mid_rst_ready", DATA_READY, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_done", DONE, 1'b0);
            chk("mid_rst_idle", DATA_READY, 1'b1);
        end

        // Back-to-back: second word offered in the DONE cycle of the first.
        n_done = 0;
        xfer(8'h3C, 1'b1);
        xfer(8'hC3, 1'b0);
        step();
        chk("b2b_done_once", DONE, 1'b0);
        chk("b2b_req_back", REQ_TOGGLE, 1'b0);
        chk("b2b_done_count", n_done, 2);
        chk("b2b_ovr", OVERRUN, 1'b0);
        step();

        // Overrun while waiting for the acknowledge of 8'h5A.
        DATA_IN    = 8'h5A;
        DATA_VALID = 1'b1;
        step();                                   // edge k
        DATA_VALID = 1'b0;
        chk("ovr_launch_req", REQ_TOGGLE, 1'b1);
        step();                                   // k+1
        DATA_IN    = 8'h77;
        DATA_VALID = 1'b1;
        step();                                   // k+2
        chk("ovr_set", OVERRUN, 1'b1);
        chk("ovr_bus_kept", DATA_BUS, 8'h5A);
        chk("ovr_req_kept", REQ_TOGGLE, 1'b1);
        OVR_CLR = 1'b1;                           // clear together with a new violation
        step();                                   // k+3
        chk("ovr_set_wins", OVERRUN, 1'b1);
        DATA_VALID = 1'b0;
        ACK_TOGGLE = 1'b1;
        step();                                   // k+4
        chk("ovr_cleared", OVERRUN, 1'b0);
        OVR_CLR = 1'b0;
        step();                                   // k+5
        chk("ovr_done_k5", DONE, 1'b0);
        step();                                   // k+6
        chk("ovr_done_k6", DONE, 1'b1);
        chk("ovr_bus_final", DATA_BUS, 8'h5A);
        step();
        chk("ovr_bus_not_77", DATA_BUS, 8'h5A);
        chk("ovr_req_final", REQ_TOGGLE, 1'b1);

        // Spurious acknowledge toggles while idle.
        for (int i = 0; i < 4; i++) begin
            ACK_TOGGLE = ~ACK_TOGGLE;
            step();
            chk("spur_done", DONE, 1'b0);
            chk("spur_ready", DATA_READY, 1'b1);
            chk("spur_req", REQ_TOGGLE, 1'b1);
            chk("spur_bus", DATA_BUS, 8'h5A);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_settle_done", DONE, 1'b0);
            chk("spur_settle_ready", DATA_READY, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule
